// File: rtl/uart_8.sv
// 8N1 UART with independent receiver (16x oversampled) and transmitter.
// Each side has its own baud generator, restarted at the start of a frame.
module uart_8 #(
    parameter int unsigned CLOCK_RATE   = 12000000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned TURBO_FRAMES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rxIn,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] rxOut,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txBusy,
    output logic       txDone,
    output logic       txOut
);

    localparam int unsigned RX_DIV = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int unsigned TX_DIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned RX_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int unsigned TX_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_READY} rxState_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

    // ---------------- receiver ----------------
    rxState_t        rxState, rxNext;
    logic            rxSync1, rxSync2;
    logic [RX_W-1:0] rxBaudCnt;
    logic            rxTick, rxBaudClr;
    logic [3:0]      rxTickCnt, rxTickCntNext;
    logic [2:0]      rxBitIdx, rxBitIdxNext;
    logic [7:0]      rxShift, rxShiftNext, rxOutNext;
    logic            rxDoneNext, rxErrNext;

    assign rxTick = (rxBaudCnt == RX_W'(RX_DIV - 1));
    assign rxBusy = (rxState == RX_START) || (rxState == RX_DATA) || (rxState == RX_STOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxSync1   <= 1'b1;
            rxSync2   <= 1'b1;
            rxState   <= RX_IDLE;
            rxBaudCnt <= '0;
            rxTickCnt <= '0;
            rxBitIdx  <= '0;
            rxShift   <= '0;
            rxOut     <= '0;
            rxDone    <= 1'b0;
            rxErr     <= 1'b0;
        end else begin
            rxSync1   <= rxIn;
            rxSync2   <= rxSync1;
            rxState   <= rxNext;
            rxBaudCnt <= (rxBaudClr || rxTick) ? '0 : rxBaudCnt + 1'b1;
            rxTickCnt <= rxTickCntNext;
            rxBitIdx  <= rxBitIdxNext;
            rxShift   <= rxShiftNext;
            rxOut     <= rxOutNext;
            rxDone    <= rxDoneNext;
            rxErr     <= rxErrNext;
        end
    end

    always_comb begin
        rxNext        = rxState;
        rxTickCntNext = rxTick ? rxTickCnt + 4'd1 : rxTickCnt;
        rxBitIdxNext  = rxBitIdx;
        rxShiftNext   = rxShift;
        rxOutNext     = rxOut;
        rxDoneNext    = 1'b0;
        rxErrNext     = 1'b0;
        rxBaudClr     = 1'b0;
        case (rxState)
            RX_IDLE: begin
                rxTickCntNext = '0;
                rxBitIdxNext  = '0;
                if (!rxSync2) begin
                    rxNext    = RX_START;
                    rxBaudClr = 1'b1;
                end
            end
            RX_START: begin
                // Mid start bit: still low means a real frame, high means a glitch.
                if (rxTick && rxTickCnt == 4'd7) begin
                    rxTickCntNext = '0;
                    rxNext        = rxSync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxTick && rxTickCnt == 4'd15) begin
                    rxShiftNext  = {rxSync2, rxShift[7:1]};
                    rxBitIdxNext = rxBitIdx + 3'd1;
                    if (rxBitIdx == 3'd7) rxNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rxTick && rxTickCnt == 4'd15) begin
                    if (rxSync2) begin
                        rxNext     = RX_READY;
                        rxOutNext  = rxShift;
                        rxDoneNext = 1'b1;
                    end else begin
                        rxNext    = RX_IDLE;
                        rxErrNext = 1'b1;
                    end
                end
            end
            RX_READY: rxNext = RX_IDLE;
            default:  rxNext = RX_IDLE;
        endcase
        if (!rxEn) begin
            rxNext     = RX_IDLE;
            rxOutNext  = rxOut;
            rxDoneNext = 1'b0;
            rxErrNext  = 1'b0;
            rxBaudClr  = 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    txState_t        txState, txNext;
    logic [TX_W-1:0] txBaudCnt;
    logic            txTick, txBaudClr, txLoad;
    logic [2:0]      txBitIdx, txBitIdxNext;
    logic [7:0]      txShift, txShiftNext;
    logic            txDoneNext, txOutNext;

    assign txTick = (txBaudCnt == TX_W'(TX_DIV - 1));
    assign txBusy = (txState != TX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState   <= TX_IDLE;
            txBaudCnt <= '0;
            txBitIdx  <= '0;
            txShift   <= '0;
            txDone    <= 1'b0;
            txOut     <= 1'b1;
        end else begin
            txState   <= txNext;
            txBaudCnt <= (txBaudClr || txTick) ? '0 : txBaudCnt + 1'b1;
            txBitIdx  <= txBitIdxNext;
            txShift   <= txShiftNext;
            txDone    <= txDoneNext;
            txOut     <= txOutNext;
        end
    end

    always_comb begin
        txNext       = txState;
        txBitIdxNext = txBitIdx;
        txShiftNext  = txShift;
        txDoneNext   = 1'b0;
        txBaudClr    = 1'b0;
        txLoad       = 1'b0;
        case (txState)
            TX_IDLE: txLoad = txStart;
            TX_START: begin
                if (txTick) begin
                    txNext       = TX_DATA;
                    txBitIdxNext = '0;
                end
            end
            TX_DATA: begin
                if (txTick) begin
                    if (txBitIdx == 3'd7) begin
                        txNext = TX_STOP;
                    end else begin
                        txBitIdxNext = txBitIdx + 3'd1;
                        txShiftNext  = {1'b0, txShift[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (txTick) begin
                    txDoneNext = 1'b1;
                    txNext     = TX_IDLE;
                    txLoad     = (TURBO_FRAMES != 0) && txStart;
                end
            end
            default: txNext = TX_IDLE;
        endcase
        if (txLoad) begin
            txNext      = TX_START;
            txShiftNext = txIn;
            txBaudClr   = 1'b1;
        end
        if (!txEn) begin
            txNext     = TX_IDLE;
            txDoneNext = 1'b0;
        end
        // Line level is registered from the next state so txOut changes with the state.
        case (txNext)
            TX_START: txOutNext = 1'b0;
            TX_DATA:  txOutNext = txShiftNext[0];
            default:  txOutNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_8.sv
// Scoreboard bench for uart_8: stimulus pushes expected rx results and tx frames,
// independent monitors pop and compare when the DUT reports completion.
module tb_uart_8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxEn = 1'b0;
    logic       rxIn = 1'b1;
    logic       txEn = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txIn = '0;
    logic       rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
    logic [7:0] rxOut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .TURBO_FRAMES(0)) dut (
        .clk(clk), .reset(reset),
        .rxEn(rxEn), .rxIn(rxIn), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
        .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         isErr;
        logic [7:0] data;
    } rxExp_t;

    rxExp_t     rxQ[$];
    logic [9:0] txQ[$];

    // ---------------- rx monitor ----------------
    rxExp_t rxE;
    logic   rxPulsePrev = 1'b0;
    always @(negedge clk) begin
        if (rxPulsePrev) chk("rx pulse width", 32'({rxDone, rxErr}), 32'd0);
        if (!reset && (rxDone || rxErr)) begin
            if (rxQ.size() == 0) begin
                chk("rx unexpected pulse", 32'({rxDone, rxErr}), 32'd0);
            end else begin
                rxE = rxQ.pop_front();
                chk("rxDone", 32'(rxDone), 32'(!rxE.isErr));
                chk("rxErr", 32'(rxErr), 32'(rxE.isErr));
                chk("rxOut", 32'(rxOut), 32'(rxE.data));
            end
        end
        rxPulsePrev = rxDone || rxErr;
    end

    // ---------------- tx monitor ----------------
    logic       txPrev = 1'b1;
    bit         txActive = 1'b0;
    int         txOff = 0;
    int         txBitN = 0;
    logic [9:0] txBits = '0;
    logic [9:0] txExp = '0;
    always @(negedge clk) begin
        if (reset || !txEn) begin
            txActive = 1'b0;
        end else if (!txActive) begin
            if (txDone) chk("txDone unexpected", 32'(txDone), 32'd0);
            if (txPrev && !txOut) begin
                txActive = 1'b1;
                txOff    = 0;
                txBitN   = 0;
                txBits   = '0;
                if (txQ.size() == 0) begin
                    chk("tx unexpected frame", 32'(txQ.size()), 32'd1);
                    txExp = '0;
                end else begin
                    txExp = txQ.pop_front();
                end
            end
        end else begin
            txOff++;
            if (txBitN < 10 && txOff == 625 + 1250 * txBitN) begin
                txBits[4'(txBitN)] = txOut;
                txBitN++;
            end
            if (txDone) begin
                chk("tx frame", 32'(txBits), 32'(txExp));
                chk("txDone timing", txOff, 32'd12500);
                chk("txBusy after done", 32'(txBusy), 32'd0);
                txActive = 1'b0;
            end else if (txOff > 13000) begin
                chk("txDone timeout", txOff, 32'd12500);
                txActive = 1'b0;
            end
        end
        txPrev = reset ? 1'b1 : txOut;
    end

    // ---------------- stimulus ----------------
    task automatic sendRx(input logic [7:0] d, input int bitClks, input logic stopVal, input int stopClks);
        rxIn = 1'b0;
        repeat (bitClks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxIn = d[i];
            repeat (bitClks) @(negedge clk);
        end
        rxIn = stopVal;
        repeat (stopClks) @(negedge clk);
        rxIn = 1'b1;
    endtask

    task automatic sendTx(input logic [7:0] d, input logic [9:0] frame);
        txIn = d;
        txQ.push_back(frame);
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic waitTxIdle();
        int n = 0;
        while (txBusy && n < 14000) begin
            @(negedge clk);
            n++;
        end
        if (txBusy) chk("tx idle timeout", 32'(txBusy), 32'd0);
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, " rxBusy"}, 32'(rxBusy), 32'd0);
        chk({tag, " rxDone"}, 32'(rxDone), 32'd0);
        chk({tag, " rxErr"},  32'(rxErr),  32'd0);
        chk({tag, " rxOut"},  32'(rxOut),  32'h00);
        chk({tag, " txBusy"}, 32'(txBusy), 32'd0);
        chk({tag, " txDone"}, 32'(txDone), 32'd0);
        chk({tag, " txOut"},  32'(txOut),  32'd1);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chkResetOutputs("reset");
        reset = 1'b0;
        rxEn  = 1'b1;
        txEn  = 1'b1;
        repeat (20) @(negedge clk);

        // Full duplex: rx 0x35 while tx 0x5A (line 0,0,1,0,1,1,0,1,0,1); a txStart mid-frame is ignored.
        rxQ.push_back('{1'b0, 8'h35});
        fork
            sendRx(8'h35, 1250, 1'b1, 1250);
            begin
                sendTx(8'h5A, 10'b1010110100);
                repeat (3000) @(negedge clk);
                txIn    = 8'hFF;
                txStart = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
                waitTxIdle();
            end
        join
        repeat (200) @(negedge clk);

        // Framing error on 0xA5 keeps rxOut=0x35; tx 0xC3 then an aborted frame.
        rxQ.push_back('{1'b1, 8'h35});
        fork
            sendRx(8'hA5, 1250, 1'b0, 700);
            begin
                sendTx(8'hC3, 10'b1110000110);
                waitTxIdle();
                repeat (50) @(negedge clk);
                sendTx(8'h00, 10'b1000000000);
                repeat (2000) @(negedge clk);
                chk("tx busy before abort", 32'(txBusy), 32'd1);
                txEn = 1'b0;
                repeat (2) @(negedge clk);
                chk("tx abort txOut", 32'(txOut), 32'd1);
                chk("tx abort txBusy", 32'(txBusy), 32'd0);
                repeat (20) @(negedge clk);
                txEn = 1'b1;
            end
        join
        repeat (1500) @(negedge clk);

        // 200-clk low glitch on idle line.
        rxIn = 1'b0;
        repeat (100) @(negedge clk);
        chk("glitch rxBusy high", 32'(rxBusy), 32'd1);
        repeat (100) @(negedge clk);
        rxIn = 1'b1;
        repeat (800) @(negedge clk);
        chk("glitch rxBusy low", 32'(rxBusy), 32'd0);

        // Bit periods 3% long.
        rxQ.push_back('{1'b0, 8'h35});
        sendRx(8'h35, 1290, 1'b1, 1290);
        repeat (300) @(negedge clk);

        // rxEn dropped mid-frame.
        rxIn = 1'b0;
        repeat (2000) @(negedge clk);
        chk("rx busy before disable", 32'(rxBusy), 32'd1);
        rxEn = 1'b0;
        @(negedge clk);
        chk("rx disable rxBusy", 32'(rxBusy), 32'd0);
        rxIn = 1'b1;
        repeat (10) @(negedge clk);
        rxEn = 1'b1;
        repeat (300) @(negedge clk);

        // Reset asserted asynchronously mid rx frame and mid tx frame.
        txQ.push_back(10'b1001111000);
        rxIn = 1'b0;
        txIn = 8'h3C;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        repeat (4000) @(negedge clk);
        chk("rx busy before reset", 32'(rxBusy), 32'd1);
        chk("tx busy before reset", 32'(txBusy), 32'd1);
        #2 reset = 1'b1;
        #1 chkResetOutputs("mid reset");
        rxIn = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (3000) @(negedge clk);
        chk("post reset rxOut", 32'(rxOut), 32'h00);
        chk("post reset txOut", 32'(txOut), 32'd1);

        chk("rx queue drained", 32'(rxQ.size()), 32'd0);
        chk("tx queue drained", 32'(txQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_8.md
UART_8 -- requirements
Module: uart_8

Interface
REQ-001 Parameter CLOCK_RATE, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 Parameter TURBO_FRAMES, default 0; when 1 the transmitter omits idle time between back-to-back frames.
REQ-004 Single clock domain, clk; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rxEn  input  1  receiver enable; low forces receiver to idle.
REQ-008 rxIn  input  1  serial line input, idle high, asynchronous to clk.
REQ-009 rxBusy  output  1  high while a frame is being received.
REQ-010 rxDone  output  1  one-clk pulse: valid byte on rxOut.
REQ-011 rxErr  output  1  one-clk pulse: framing error (stop bit sampled low).
REQ-012 rxOut  output  8  last correctly received byte.
REQ-013 txEn  input  1  transmitter enable; low forces txOut high and idle.
REQ-014 txStart  input  1  request to send txIn; sampled when transmitter idle.
REQ-015 txIn  input  8  byte to transmit.
REQ-016 txBusy  output  1  high while a frame is being sent.
REQ-017 txDone  output  1  one-clk pulse at end of stop bit.
REQ-018 txOut  output  1  serial line output, idle high.

Function
REQ-019 Baud generators: rx tick every round(CLOCK_RATE/(BAUD_RATE*16)) clks (78 at defaults); tx tick every round(CLOCK_RATE/BAUD_RATE) clks (1250 at defaults); each counter wraps to 0 on tick.
REQ-020 rxIn passes through a 2-flop synchronizer before any use.
REQ-021 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-022 Rx FSM states: IDLE, START, DATA, STOP, READY.
REQ-023 IDLE -> START on synchronized rxIn low with rxEn high; rx tick counter restarts at the edge.
REQ-024 START: after 8 rx ticks, rxIn still low -> DATA; rxIn high -> IDLE (glitch rejected, no rxErr).
REQ-025 DATA: sample every 16 rx ticks (mid-bit), shift into bit index 0..7; after bit 7 -> STOP.
REQ-026 STOP: after 16 rx ticks, sample; high -> READY, load rxOut, pulse rxDone; low -> pulse rxErr, rxOut unchanged, go to IDLE.
REQ-027 READY -> IDLE the next clk; new start bit detectable immediately after.
REQ-028 rxBusy high in START, DATA, STOP; low in IDLE and READY.
REQ-029 rxEn low at any time: receiver returns to IDLE within one clk, no rxDone/rxErr for the aborted frame.
REQ-030 Tx FSM states: IDLE, START, DATA, STOP.
REQ-031 IDLE with txEn and txStart high: latch txIn, txBusy high next clk, tx bit counter restarts; txStart while busy ignored.
REQ-032 Each tx bit held exactly one tx-tick period (1250 clks at defaults): start 0, data LSB first, stop 1.
REQ-033 End of stop bit: pulse txDone one clk, return to IDLE; if TURBO_FRAMES=1 and txStart high, start next frame on same clk, else at least one clk idle.
REQ-034 txEn low mid-frame: abort, txOut high, txBusy low, no txDone.
REQ-035 Receiver and transmitter independent; full-duplex operation allowed.

Reset
REQ-036 While reset high: both FSMs IDLE, counters 0, rxOut=0x00, rxBusy/rxDone/rxErr=0, txBusy/txDone=0, txOut=1, synchronizer flops=1.
REQ-037 Reset asserted mid-frame aborts it immediately; no done/error pulse on release.

Verification
REQ-038 Rx 0x35 at 9600 baud, bit period 1250 clks, stop high -> rxDone one clk, rxOut=0x35, rxErr=0.
REQ-039 Rx 0xA5 with stop bit low -> rxErr one clk, rxDone=0, rxOut keeps prior value.
REQ-040 Rx low glitch of 200 clks on idle line -> returns to IDLE, no rxDone/rxErr, rxBusy drops.
REQ-041 Rx bit periods 3% longer than nominal (1290 clks) for 0x35 -> rxOut=0x35 correctly.
REQ-042 Tx 0x5A with txStart pulse -> txOut sequence 0,0,1,0,1,1,0,1,0,1 each 1250 clks, txDone one clk, txBusy low after.
REQ-043 Reset asserted mid rx frame and mid tx frame -> all outputs at reset values, txOut=1, no pulses.
